regfile_writeback: RTL and testbench

Writeback stage that owns the single write port of the register file: captures retiring instructions from MEM, aligns load data, generates per-byte write enables (including LWL/LWR partial writes), and merges results from the multicycle mul/div unit through a one-entry hold buffer with starvation protection. Drives rf_we/rf_waddr/rf_wdata straight into the register file and exposes forwarding and pending-result status to decode.

---
 rtl/regfile_writeback.sv | 187 ++++++++++++++++++
 tb/tb_regfile_writeback.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Writeback stage owning the register-file write port: load alignment, LWL/LWR byte enables,
// and a one-entry mul/div hold buffer that drains in idle slots with an anti-starvation throttle.
module regfile_writeback #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    output logic        wb_ready,
    input  logic [3:0]  mem_op,
    input  logic [4:0]  mem_dest,
    input  logic [31:0] mem_result,
    input  logic [1:0]  mem_addr_lo,
    input  logic [31:0] dram_rdata,
    input  logic        muldiv_valid,
    output logic        muldiv_ready,
    input  logic [4:0]  muldiv_dest,
    input  logic [31:0] muldiv_data,
    output logic [3:0]  rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        fwd_valid,
    output logic [4:0]  fwd_dest,
    output logic [31:0] fwd_data,
    output logic        hold_valid,
    output logic [4:0]  hold_dest
);

    localparam int AGE_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    localparam logic [3:0] OP_ALU = 4'd1;
    localparam logic [3:0] OP_LB  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd3;
    localparam logic [3:0] OP_LH  = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_LW  = 4'd6;
    localparam logic [3:0] OP_LWL = 4'd7;
    localparam logic [3:0] OP_LWR = 4'd8;

    logic             r_valid;
    logic [3:0]       r_op;
    logic [4:0]       r_dest;
    logic [31:0]      r_result;
    logic [1:0]       r_addr_lo;
    logic             r_hold_valid;
    logic [4:0]       r_hold_dest;
    logic [31:0]      r_hold_data;
    logic [AGE_W-1:0] r_age;

    logic        w_accept;
    logic        w_hold_accept;
    logic        w_stage_req;
    logic        w_drain;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_we;
    logic [4:0]  w_waddr;
    logic [31:0] w_wdata;

    assign w_accept      = mem_valid && wb_ready;
    assign w_hold_accept = muldiv_valid && !r_hold_valid;
    assign w_stage_req   = r_valid && (r_op >= OP_ALU) && (r_op <= OP_LWR) && (r_dest != 5'd0);
    assign w_drain       = r_hold_valid && !w_stage_req;

    // Stage register: loads on handshake, otherwise becomes a bubble
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid   <= 1'b0;
            r_op      <= 4'd0;
            r_dest    <= 5'd0;
            r_result  <= 32'd0;
            r_addr_lo <= 2'd0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_op      <= mem_op;
                r_dest    <= mem_dest;
                r_result  <= mem_result;
                r_addr_lo <= mem_addr_lo;
            end
        end
    end

    // Hold buffer: fills only when empty, so no accept can overlap a drain
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_valid <= 1'b0;
            r_hold_dest  <= 5'd0;
            r_hold_data  <= 32'd0;
        end else if (w_hold_accept) begin
            r_hold_valid <= 1'b1;
            r_hold_dest  <= muldiv_dest;
            r_hold_data  <= muldiv_data;
        end else if (w_drain) begin
            r_hold_valid <= 1'b0;
        end
    end

    // Age of the held result; saturates at the limit to throttle MEM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_age <= '0;
        end else if (!r_hold_valid || w_drain) begin
            r_age <= '0;
        end else if (r_age != AGE_MAX) begin
            r_age <= r_age + AGE_W'(1);
        end
    end

    // Extract the addressed byte and halfword of the load word
    always_comb begin
        w_byte = 8'd0;
        case (r_addr_lo)
            2'd0:    w_byte = dram_rdata[7:0];
            2'd1:    w_byte = dram_rdata[15:8];
            2'd2:    w_byte = dram_rdata[23:16];
            2'd3:    w_byte = dram_rdata[31:24];
            default: w_byte = 8'd0;
        endcase
        if (r_addr_lo[1]) begin
            w_half = dram_rdata[31:16];
        end else begin
            w_half = dram_rdata[15:0];
        end
    end

    // Write-port arbitration and data formatting; stage beats hold
    always_comb begin
        w_we    = 4'b0000;
        w_waddr = 5'd0;
        w_wdata = 32'd0;
        if (w_stage_req) begin
            w_waddr = r_dest;
            w_we    = 4'b1111;
            case (r_op)
                OP_ALU:  w_wdata = r_result;
                OP_LB:   w_wdata = {{24{w_byte[7]}}, w_byte};
                OP_LBU:  w_wdata = {24'd0, w_byte};
                OP_LH:   w_wdata = {{16{w_half[15]}}, w_half};
                OP_LHU:  w_wdata = {16'd0, w_half};
                OP_LW:   w_wdata = dram_rdata;
                OP_LWL: begin
                    case (r_addr_lo)
                        2'd0:    begin w_we = 4'b1000; w_wdata = {dram_rdata[7:0], 24'd0};  end
                        2'd1:    begin w_we = 4'b1100; w_wdata = {dram_rdata[15:0], 16'd0}; end
                        2'd2:    begin w_we = 4'b1110; w_wdata = {dram_rdata[23:0], 8'd0};  end
                        default: begin w_we = 4'b1111; w_wdata = dram_rdata;                end
                    endcase
                end
                OP_LWR: begin
                    case (r_addr_lo)
                        2'd0:    begin w_we = 4'b1111; w_wdata = dram_rdata;                 end
                        2'd1:    begin w_we = 4'b0111; w_wdata = {8'd0, dram_rdata[31:8]};  end
                        2'd2:    begin w_we = 4'b0011; w_wdata = {16'd0, dram_rdata[31:16]}; end
                        default: begin w_we = 4'b0001; w_wdata = {24'd0, dram_rdata[31:24]}; end
                    endcase
                end
                default: begin
                    w_we    = 4'b0000;
                    w_waddr = 5'd0;
                end
            endcase
        end else if (w_drain && (r_hold_dest != 5'd0)) begin
            w_we    = 4'b1111;
            w_waddr = r_hold_dest;
            w_wdata = r_hold_data;
        end else begin
            w_we    = 4'b0000;
            w_waddr = 5'd0;
            w_wdata = 32'd0;
        end
    end

    // The drain bubble re-opens MEM so the throttle lasts a single cycle
    assign wb_ready     = (r_age != AGE_MAX) || w_drain;
    assign muldiv_ready = !r_hold_valid;
    assign rf_we        = w_we;
    assign rf_waddr     = w_waddr;
    assign rf_wdata     = w_wdata;
    assign fwd_valid    = (w_we != 4'b0000);
    assign fwd_dest     = w_waddr;
    assign fwd_data     = w_wdata;
    assign hold_valid   = r_hold_valid;
    assign hold_dest    = r_hold_dest;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed self-checking bench for regfile_writeback with a byte-enable register file model.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic        wb_ready;
    logic [3:0]  mem_op;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;
    logic [1:0]  mem_addr_lo;
    logic [31:0] dram_rdata;
    logic        muldiv_valid;
    logic        muldiv_ready;
    logic [4:0]  muldiv_dest;
    logic [31:0] muldiv_data;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        fwd_valid;
    logic [4:0]  fwd_dest;
    logic [31:0] fwd_data;
    logic        hold_valid;
    logic [4:0]  hold_dest;

    int checks   = 0;
    int failures = 0;
    logic [31:0] tb_rf [32];

    localparam logic [31:0] LD_EXP [16] = '{
        32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
        32'h00000001, 32'h0000007F, 32'h000000FF, 32'h00000080,
        32'h00007F01, 32'h00007F01, 32'hFFFF80FF, 32'hFFFF80FF,
        32'h00007F01, 32'h00007F01, 32'h000080FF, 32'h000080FF};
    localparam logic [31:0] LWX_EXP [8] = '{
        32'hDD000000, 32'hCCDD0000, 32'hBBCCDD00, 32'hAABBCCDD,
        32'hAABBCCDD, 32'h00AABBCC, 32'h0000AABB, 32'h000000AA};
    localparam logic [3:0] LWX_WE [8] = '{
        4'b1000, 4'b1100, 4'b1110, 4'b1111,
        4'b1111, 4'b0111, 4'b0011, 4'b0001};

    regfile_writeback #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .wb_ready(wb_ready),
        .mem_op(mem_op), .mem_dest(mem_dest), .mem_result(mem_result),
        .mem_addr_lo(mem_addr_lo), .dram_rdata(dram_rdata),
        .muldiv_valid(muldiv_valid), .muldiv_ready(muldiv_ready),
        .muldiv_dest(muldiv_dest), .muldiv_data(muldiv_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
        .hold_valid(hold_valid), .hold_dest(hold_dest)
    );

    always #5 clk = ~clk;

    // Register file model: byte-enabled writes on the clock edge
    always @(posedge clk) begin
        if (resetn) begin
            for (int b = 0; b < 4; b++) begin
                if (rf_we[b]) tb_rf[rf_waddr][8*b +: 8] <= rf_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one MEM entry, then hold the stage with the given load data
    task automatic issue(input logic [3:0] op, input logic [4:0] dest, input logic [31:0] res,
                         input logic [1:0] alo, input logic [31:0] rdata);
        mem_valid = 1'b1; mem_op = op; mem_dest = dest; mem_result = res; mem_addr_lo = alo;
        tick();
        mem_valid = 1'b0;
        dram_rdata = rdata;
        #1;
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] we);
        return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    endfunction

    initial begin
        logic [6:0] exp_rdy;
        logic [6:0] exp_hold;
        logic [6:0] exp_mdr;
        int idx;
        for (int r = 0; r < 32; r++) tb_rf[r] = 32'd0;
        resetn = 1'b0; mem_valid = 1'b0; mem_op = 4'd0; mem_dest = 5'd0; mem_result = 32'd0;
        mem_addr_lo = 2'd0; dram_rdata = 32'd0; muldiv_valid = 1'b0; muldiv_dest = 5'd0;
        muldiv_data = 32'd0;
        tick(); tick();
        check("rst_we", {28'd0, rf_we}, 32'd0);
        check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_fwd", {31'd0, fwd_valid}, 32'd0);
        check("rst_hold", {31'd0, hold_valid}, 32'd0);
        check("rst_hdest", {27'd0, hold_dest}, 32'd0);
        check("rst_wbrdy", {31'd0, wb_ready}, 32'd1);
        check("rst_mdrdy", {31'd0, muldiv_ready}, 32'd1);
        resetn = 1'b1;
        tick();

        issue(4'd1, 5'd5, 32'h12345678, 2'd0, 32'd0);
        check("alu_we", {28'd0, rf_we}, 32'hF);
        check("alu_waddr", {27'd0, rf_waddr}, 32'd5);
        check("alu_wdata", rf_wdata, 32'h12345678);
        check("alu_fwd", {31'd0, fwd_valid}, 32'd1);
        check("alu_fdest", {27'd0, fwd_dest}, 32'd5);
        check("alu_fdata", fwd_data, 32'h12345678);

        for (int i = 0; i < 16; i++) begin
            issue(4'(2 + i / 4), 5'd3, 32'd0, 2'(i % 4), 32'h80FF7F01);
            check($sformatf("ld%0d_a%0d_wdata", 2 + i / 4, i % 4), rf_wdata, LD_EXP[i]);
            check($sformatf("ld%0d_a%0d_we", 2 + i / 4, i % 4), {28'd0, rf_we}, 32'hF);
        end
        issue(4'd6, 5'd3, 32'd0, 2'd2, 32'h80FF7F01);
        check("lw_wdata", rf_wdata, 32'h80FF7F01);

        for (int i = 0; i < 8; i++) begin
            issue(4'(7 + i / 4), 5'd4, 32'd0, 2'(i % 4), 32'hAABBCCDD);
            check($sformatf("lw%s_a%0d_we", (i < 4) ? "l" : "r", i % 4), {28'd0, rf_we},
                  {28'd0, LWX_WE[i]});
            check($sformatf("lw%s_a%0d_wdata", (i < 4) ? "l" : "r", i % 4),
                  rf_wdata & be_mask(LWX_WE[i]), LWX_EXP[i]);
        end

        issue(4'd1, 5'd7, 32'h11223344, 2'd0, 32'd0);
        issue(4'd7, 5'd7, 32'd0, 2'd1, 32'hAABBCCDD);
        issue(4'd1, 5'd8, 32'h11223344, 2'd0, 32'd0);
        issue(4'd8, 5'd8, 32'd0, 2'd2, 32'hAABBCCDD);
        issue(4'd1, 5'd0, 32'hFFFFFFFF, 2'd0, 32'd0);
        check("dest0_we", {28'd0, rf_we}, 32'd0);
        check("dest0_fwd", {31'd0, fwd_valid}, 32'd0);
        tick();
        check("merge_lwl", tb_rf[7], 32'hCCDD3344);
        check("merge_lwr", tb_rf[8], 32'h1122AABB);

        muldiv_valid = 1'b1; muldiv_dest = 5'd9; muldiv_data = 32'hDEADBEEF;
        tick();
        muldiv_valid = 1'b0;
        check("md_hold", {31'd0, hold_valid}, 32'd1);
        check("md_hdest", {27'd0, hold_dest}, 32'd9);
        check("md_mdrdy", {31'd0, muldiv_ready}, 32'd0);
        check("md_waddr", {27'd0, rf_waddr}, 32'd9);
        check("md_wdata", rf_wdata, 32'hDEADBEEF);
        tick();
        check("md_clear", {31'd0, hold_valid}, 32'd0);
        check("md_mdrdy2", {31'd0, muldiv_ready}, 32'd1);
        check("md_rf", tb_rf[9], 32'hDEADBEEF);

        muldiv_valid = 1'b1; muldiv_dest = 5'd0; muldiv_data = 32'h01020304;
        tick();
        muldiv_valid = 1'b0;
        check("md0_hold", {31'd0, hold_valid}, 32'd1);
        check("md0_we", {28'd0, rf_we}, 32'd0);
        check("md0_fwd", {31'd0, fwd_valid}, 32'd0);
        tick();
        check("md0_clear", {31'd0, hold_valid}, 32'd0);

        // Starvation: continuous ALU stream with one mul/div result waiting behind it
        exp_rdy  = 7'b1101111;
        exp_hold = 7'b0111111;
        exp_mdr  = 7'b1000000;
        mem_valid = 1'b1; mem_op = 4'd1; mem_dest = 5'd10; mem_result = 32'h00000100;
        tick(); tick();
        muldiv_valid = 1'b1; muldiv_dest = 5'd11; muldiv_data = 32'hCAFEF00D;
        tick();
        muldiv_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check($sformatf("starve_k%0d_wbrdy", k), {31'd0, wb_ready}, {31'd0, exp_rdy[k]});
            check($sformatf("starve_k%0d_hold", k), {31'd0, hold_valid}, {31'd0, exp_hold[k]});
            check($sformatf("starve_k%0d_mdrdy", k), {31'd0, muldiv_ready}, {31'd0, exp_mdr[k]});
            check($sformatf("starve_k%0d_waddr", k), {27'd0, rf_waddr}, (k == 5) ? 32'd11 : 32'd10);
            if (k == 5) check("starve_wdata", rf_wdata, 32'hCAFEF00D);
            tick();
        end
        mem_valid = 1'b0;
        tick();
        check("starve_rf", tb_rf[11], 32'hCAFEF00D);

        // Asynchronous reset while a result is held behind the stream
        mem_valid = 1'b1; mem_dest = 5'd12;
        muldiv_valid = 1'b1; muldiv_dest = 5'd13; muldiv_data = 32'h5555AAAA;
        tick();
        muldiv_valid = 1'b0;
        tick();
        idx = 13;
        check("arst_pre_hold", {31'd0, hold_valid}, 32'd1);
        mem_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check("arst_hold", {31'd0, hold_valid}, 32'd0);
        check("arst_we", {28'd0, rf_we}, 32'd0);
        check("arst_fwd", {31'd0, fwd_valid}, 32'd0);
        check("arst_mdrdy", {31'd0, muldiv_ready}, 32'd1);
        tick();
        resetn = 1'b1;
        tick(); tick(); tick();
        check("arst_no_write", tb_rf[idx], 32'd0);
        check("arst_hold_after", {31'd0, hold_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
